// File: rtl/chip8_vga_scanout_pkg.sv
// Shared CHIP-8 video constants and types for the scanout and the CPU side.
// The CHIP8_SCANLINE_EN build option is applied in chip8_vga_scanout.sv.
package chip8_vga_scanout_pkg;

    localparam int FB_W_LO          = 64;
    localparam int FB_H_LO          = 32;
    localparam int FB_W_HI          = 128;
    localparam int FB_H_HI          = 64;
    localparam int WORDS_PER_ROW_LO = FB_W_LO / 16;
    localparam int WORDS_PER_ROW_HI = FB_W_HI / 16;
    localparam int SCALE_X_LO       = 10;
    localparam int SCALE_X_HI       = 5;
    localparam int SCALE_Y_LO       = 14;
    localparam int SCALE_Y_HI       = 7;

    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_LSB = 0;

    localparam int ADDR_W = 9;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic    hsync;
        logic    vsync;
        logic    de;
        logic    vblank;
        rgb332_t rgb;
    } vga_out_t;

    localparam vga_out_t VGA_OUT_RESET = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0,
                                           vblank: 1'b0, rgb: 8'h00};

    // Halve every RGB332 channel independently (scanline darkening).
    function automatic rgb332_t rgb332_dim(input rgb332_t c);
        rgb332_t d;
        d = '0;
        d[RGB_R_LSB +: 3] = c[RGB_R_LSB +: 3] >> 1;
        d[RGB_G_LSB +: 3] = c[RGB_G_LSB +: 3] >> 1;
        d[RGB_B_LSB +: 2] = c[RGB_B_LSB +: 2] >> 1;
        return d;
    endfunction

endpackage

// File: rtl/chip8_vga_scanout_if.sv
// Framebuffer read port A: the scanout drives the word address, the RAM returns data one cycle later.
interface chip8_vga_scanout_if;
    import chip8_vga_scanout_pkg::*;

    logic [ADDR_W-1:0] vgabuf_addr;
    logic [15:0]       vgabuf_data;

    modport master (output vgabuf_addr, input vgabuf_data);
    modport slave  (input vgabuf_addr, output vgabuf_data);
endinterface

// File: rtl/chip8_vga_scanout_vga_timing.sv
// Free-running VGA raster counters with un-delayed sync, active-area and vblank decodes.
module chip8_vga_scanout_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vgaClk,
    input  logic       rst,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       vblank
);

    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vgaClk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign hsync  = !((h >= HS_START) && (h < HS_END));
    assign vsync  = !((v >= VS_START) && (v < VS_END));
    assign active = (h < H_ACT) && (v < V_ACT);
    assign vblank = (h == 10'd0) && (v == V_ACT);

endmodule

// File: rtl/chip8_vga_scanout.sv
// CHIP-8 framebuffer scanout: fetches 16-bit words, serialises scaled pixels, drives VGA RGB332.
// Build option CHIP8_SCANLINE_EN darkens odd picture rows; timing is identical either way.
module chip8_vga_scanout
    import chip8_vga_scanout_pkg::*;
#(
    parameter int      H_ACTIVE = 640,
    parameter int      H_FP     = 16,
    parameter int      H_SYNC   = 96,
    parameter int      H_BP     = 48,
    parameter int      V_ACTIVE = 480,
    parameter int      V_FP     = 10,
    parameter int      V_SYNC   = 2,
    parameter int      V_BP     = 33,
    parameter int      V_BORDER = 16,
    parameter rgb332_t FG_COLOR = 8'hFF,
    parameter rgb332_t BG_COLOR = 8'h00
) (
    input  logic                vgaClk,
    input  logic                rst,
    input  logic                hires,
    chip8_vga_scanout_if.master fb,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_de,
    output rgb332_t             vga_rgb,
    output logic                vblank
);

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_FETCH   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] WIN_START = 10'(V_BORDER);
    localparam logic [9:0] WIN_END   = 10'(V_ACTIVE - V_BORDER);

    logic [9:0] h, v;
    logic       t_hsync, t_vsync, t_active, t_vblank;

    chip8_vga_scanout_vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .vgaClk (vgaClk),
        .rst    (rst),
        .h      (h),
        .v      (v),
        .hsync  (t_hsync),
        .vsync  (t_vsync),
        .active (t_active),
        .vblank (t_vblank)
    );

    logic              hires_q;
    logic [3:0]        hsub;
    logic [3:0]        pbit;
    logic [3:0]        vsub;
    logic [5:0]        row;
    logic [15:0]       shreg;
    logic [ADDR_W-1:0] addr_q;

    logic              sx_last;
    logic [3:0]        sy_last;
    logic [5:0]        row_max;
    logic [9:0]        v_next;
    logic [3:0]        vsub_nxt;
    logic [5:0]        row_nxt;
    logic [ADDR_W-1:0] row_base;

    assign sx_last = (hsub == (hires_q ? 4'(SCALE_X_HI - 1) : 4'(SCALE_X_LO - 1)));
    assign sy_last = hires_q ? 4'(SCALE_Y_HI - 1) : 4'(SCALE_Y_LO - 1);
    assign row_max = hires_q ? 6'(FB_H_HI - 1) : 6'(FB_H_LO - 1);
    assign v_next  = (v == V_LAST) ? 10'd0 : v + 10'd1;

    // Vertical scaling is tracked for the line about to be fetched, one line ahead of the display.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        vsub_nxt = vsub;
        row_nxt  = row;
        if (v_next == WIN_START) begin
            vsub_nxt = '0;
            row_nxt  = '0;
        end else if ((v_next > WIN_START) && (v_next < WIN_END)) begin
            if (vsub == sy_last) begin
                vsub_nxt = '0;
                if (row != row_max) row_nxt = row + 6'd1;
            end else begin
                vsub_nxt = vsub + 4'd1;
            end
        end
    end

    assign row_base = hires_q ? ADDR_W'(row_nxt) * ADDR_W'(WORDS_PER_ROW_HI)
                              : ADDR_W'(row_nxt) * ADDR_W'(WORDS_PER_ROW_LO);

    // Word n+1 is addressed when word n enters the shift register, giving a full word of lead time.
    always_ff @(posedge vgaClk) begin
        if (rst) begin
            hires_q <= 1'b0;
            hsub    <= '0;
            pbit    <= '0;
            vsub    <= '0;
            row     <= '0;
            shreg   <= '0;
            addr_q  <= '0;
        end else begin
            if ((h == 10'd0) && (v == 10'd0)) hires_q <= hires;
            if (h == H_FETCH) begin
                vsub   <= vsub_nxt;
                row    <= row_nxt;
                addr_q <= row_base;
            end
            if (h == H_LAST) begin
                hsub   <= '0;
                pbit   <= '0;
                shreg  <= fb.vgabuf_data;
                addr_q <= addr_q + ADDR_W'(1);
            end else if (h < H_FETCH) begin
                if (sx_last) begin
                    hsub <= '0;
                    pbit <= pbit + 4'd1;
                    if (pbit == 4'hF) begin
                        shreg  <= fb.vgabuf_data;
                        addr_q <= addr_q + ADDR_W'(1);
                    end else begin
                        shreg <= shreg << 1;
                    end
                end else begin
                    hsub <= hsub + 4'd1;
                end
            end
        end
    end

    assign fb.vgabuf_addr = addr_q;

    vga_out_t pix_d, pipe_q1, pipe_q2;
    logic     in_window;

    assign in_window = t_active && (v >= WIN_START) && (v < WIN_END);

    always_comb begin
        pix_d.hsync  = t_hsync;
        pix_d.vsync  = t_vsync;
        pix_d.de     = t_active;
        pix_d.vblank = t_vblank;
        pix_d.rgb    = 8'h00;
        if (in_window) begin
            pix_d.rgb = shreg[15] ? FG_COLOR : BG_COLOR;
`ifdef CHIP8_SCANLINE_EN
            if (v[0]) pix_d.rgb = rgb332_dim(pix_d.rgb);
`endif
        end else if (t_active) begin
            pix_d.rgb = BG_COLOR;
        end
    end

    // NOTE: the output pipe is reset as well, so syncs sit idle-high from the first cycle after reset.
    always_ff @(posedge vgaClk) begin
        if (rst) begin
            pipe_q1 <= VGA_OUT_RESET;
            pipe_q2 <= VGA_OUT_RESET;
        end else begin
            pipe_q1 <= pix_d;
            pipe_q2 <= pipe_q1;
        end
    end

    assign vga_hsync = pipe_q2.hsync;
    assign vga_vsync = pipe_q2.vsync;
    assign vga_de    = pipe_q2.de;
    assign vblank    = pipe_q2.vblank;
    assign vga_rgb   = pipe_q2.rgb;

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Scoreboard bench for chip8_vga_scanout on a vertically shortened raster (full 800-cycle lines).
module tb_chip8_vga_scanout;
    import chip8_vga_scanout_pkg::*;

    localparam int V_ACTIVE = 32;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int V_BORDER = 4;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic    vgaClk = 1'b0;
    logic    rst    = 1'b1;
    logic    hires  = 1'b1;
    logic    vga_hsync, vga_vsync, vga_de, vblank;
    rgb332_t vga_rgb;

    chip8_vga_scanout_if fb_if ();

    chip8_vga_scanout #(
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .V_BORDER (V_BORDER)
    ) dut (
        .vgaClk    (vgaClk),
        .rst       (rst),
        .hires     (hires),
        .fb        (fb_if),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_de    (vga_de),
        .vga_rgb   (vga_rgb),
        .vblank    (vblank)
    );

    always #20 vgaClk = ~vgaClk;

    logic [15:0] mem [0:511];
    always @(posedge vgaClk) fb_if.vgabuf_data <= mem[fb_if.vgabuf_addr];

    typedef struct { int fr; int h; int v; logic [11:0] val; } pix_exp_t;
    typedef struct { int fr; int h; int v; logic [8:0] addr; } addr_exp_t;
    pix_exp_t  pix_q[$];
    addr_exp_t addr_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic rgb332_t fg_at(input int v);
`ifdef CHIP8_SCANLINE_EN
        return (v % 2 == 1) ? 8'h6D : 8'hFF;
`else
        return 8'hFF;
`endif
    endfunction

    // Expected {de, hsync, vsync, vblank, rgb} at raster position (h, v).
    task automatic push_pix(input int fr, input int h, input int v, input bit fg);
        pix_exp_t e;
        logic de, hs, vs, vb;
        de = (h < 640) && (v < V_ACTIVE);
        hs = !((h >= 656) && (h < 752));
        vs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
        vb = (h == 0) && (v == V_ACTIVE);
        e.fr = fr; e.h = h; e.v = v;
        e.val = {de, hs, vs, vb, (fg ? fg_at(v) : 8'h00)};
        pix_q.push_back(e);
    endtask

    task automatic push_addr(input int fr, input int h, input int v, input int a);
        addr_exp_t e;
        e.fr = fr; e.h = h; e.v = v; e.addr = 9'(a);
        addr_q.push_back(e);
    endtask

    // Monitor: k is the raster counter position of the current cycle since reset release.
    int k = -1, epoch = -1;
    bit in_rst = 1'b0, hs_seen = 1'b0;
    int hs_low = 0, vs_low = 0, vb_cnt = 0;

    always @(negedge vgaClk) begin
        if (rst) begin
            if (!in_rst) epoch++;
            in_rst  = 1'b1;
            k       = -1;
            hs_seen = 1'b0;
        end else begin
            in_rst = 1'b0;
            k++;
            if (k < 2) begin
                check($sformatf("reset_out k=%0d", k),
                      {vga_de, vga_hsync, vga_vsync, vblank, vga_rgb}, 12'b0110_0000_0000);
                check($sformatf("reset_addr k=%0d", k), fb_if.vgabuf_addr, 0);
            end
            if (!hs_seen && !vga_hsync) begin
                hs_seen = 1'b1;
                check("first_hsync_fall_cycle", k, 658);
            end
            if (epoch == 0) begin
                for (int i = addr_q.size() - 1; i >= 0; i--) begin
                    if (addr_q[i].fr * FRAME + addr_q[i].v * H_TOTAL + addr_q[i].h == k) begin
                        check($sformatf("addr f%0d h%0d v%0d", addr_q[i].fr, addr_q[i].h, addr_q[i].v),
                              fb_if.vgabuf_addr, addr_q[i].addr);
                        addr_q.delete(i);
                    end
                end
                if (k >= 2) begin
                    for (int i = pix_q.size() - 1; i >= 0; i--) begin
                        if (pix_q[i].fr * FRAME + pix_q[i].v * H_TOTAL + pix_q[i].h == k - 2) begin
                            check($sformatf("pix f%0d h%0d v%0d", pix_q[i].fr, pix_q[i].h, pix_q[i].v),
                                  {vga_de, vga_hsync, vga_vsync, vblank, vga_rgb}, pix_q[i].val);
                            pix_q.delete(i);
                        end
                    end
                    if ((k - 2) < 2 * FRAME) begin
                        hs_low += int'(!vga_hsync);
                        vs_low += int'(!vga_vsync);
                        vb_cnt += int'(vblank);
                        if ((k - 2) % FRAME == FRAME - 1) begin
                            check("hsync_low_per_frame", hs_low, 96 * V_TOTAL);
                            check("vsync_low_per_frame", vs_low, V_SYNC * H_TOTAL);
                            check("vblank_per_frame", vb_cnt, 1);
                            hs_low = 0; vs_low = 0; vb_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h8001;
        mem[3]  = 16'h0001;
        mem[4]  = 16'hC000;
        mem[8]  = 16'h4000;
        mem[16] = 16'h8000;
        mem[24] = 16'hFFFF;

        // Frame 0, hi-res: rows are 7 lines, pixels 5 columns, 8 words per row.
        push_pix(0, 0, 3, 0);
        push_pix(0, 0, 4, 1);  push_pix(0, 4, 4, 1);  push_pix(0, 5, 4, 0);
        push_pix(0, 74, 4, 0); push_pix(0, 75, 4, 1); push_pix(0, 79, 4, 1);
        push_pix(0, 80, 4, 0); push_pix(0, 639, 4, 0); push_pix(0, 640, 4, 0);
        push_pix(0, 655, 5, 0); push_pix(0, 656, 5, 0); push_pix(0, 751, 5, 0); push_pix(0, 752, 5, 0);
        push_pix(0, 0, 10, 1); push_pix(0, 40, 10, 0); push_pix(0, 79, 10, 1);
        push_pix(0, 0, 11, 0); push_pix(0, 5, 11, 1); push_pix(0, 9, 11, 1); push_pix(0, 10, 11, 0);
        push_pix(0, 2, 18, 1); push_pix(0, 7, 18, 0);
        push_pix(0, 0, 27, 1); push_pix(0, 0, 28, 0);
        push_pix(0, 0, 32, 0); push_pix(0, 1, 32, 0); push_pix(0, 100, 33, 0);
        push_pix(0, 0, 34, 0); push_pix(0, 799, 35, 0); push_pix(0, 0, 36, 0);
        push_addr(0, 700, 10, 8); push_addr(0, 40, 11, 9);
        push_addr(0, 700, 20, 16); push_addr(0, 700, 24, 24);

        repeat (4) @(posedge vgaClk);
        #1 rst = 1'b0;

        // Mode change mid-frame must not touch addressing until the next frame start.
        repeat (16 * H_TOTAL) @(posedge vgaClk);
        #1 hires = 1'b0;

        // Frame 1, lo-res: rows are 14 lines, pixels 10 columns, 4 words per row.
        push_pix(1, 0, 4, 1);   push_pix(1, 9, 4, 1);   push_pix(1, 10, 4, 0);
        push_pix(1, 150, 4, 1); push_pix(1, 159, 4, 1); push_pix(1, 160, 4, 0);
        push_pix(1, 629, 4, 0); push_pix(1, 630, 4, 1); push_pix(1, 639, 4, 1);
        push_pix(1, 640, 4, 0);
        push_pix(1, 635, 17, 1); push_pix(1, 635, 18, 0);
        push_pix(1, 7, 18, 1);  push_pix(1, 19, 18, 1); push_pix(1, 20, 18, 0);
        push_pix(1, 0, 28, 0);
        push_addr(1, 100, 4, 1); push_addr(1, 700, 4, 0); push_addr(1, 700, 17, 4);

        repeat (2 * FRAME + 10 * H_TOTAL + 300 - 16 * H_TOTAL) @(posedge vgaClk);
        #1 rst = 1'b1;
        @(posedge vgaClk);
        #1 rst = 1'b0;
        repeat (H_TOTAL) @(posedge vgaClk);
        #1;
        check("hsync_fell_after_reset", 32'(hs_seen), 1);
        check("pix_entries_unreached", pix_q.size(), 0);
        check("addr_entries_unreached", addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
